// File: rtl/ec1_controller.sv
// EC-1 control unit: Moore fetch/decode/execute FSM driving the accumulator datapath,
// with Enter-key rising-edge detection for the IN instruction.
module ec1_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       Enter,
  input  logic [2:0] IR7_5,
  input  logic       A,
  output logic       IRload,
  output logic       PCload,
  output logic       JNZmux,
  output logic       INmux,
  output logic       Aload,
  output logic       OutE,
  output logic       Halt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_START  = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_INPUT  = 3'b011,
    S_OUTPUT = 3'b100,
    S_DEC    = 3'b101,
    S_JNZ    = 3'b110,
    S_HALT   = 3'b111
  } state_t;

  state_t state_reg, state_next;
  logic   enter_q_reg;
  logic   enter_edge;

  // A key already down on entry to INPUT shows no edge, so it must be re-pressed.
  assign enter_edge = Enter & ~enter_q_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_START;
      enter_q_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      enter_q_reg <= Enter;
    end
  end

  always_comb begin
    state_next = state_reg;
    IRload     = 1'b0;
    PCload     = 1'b0;
    JNZmux     = 1'b0;
    INmux      = 1'b0;
    Aload      = 1'b0;
    OutE       = 1'b0;
    Halt       = 1'b0;
    unique case (state_reg)
      S_START: state_next = S_FETCH;
      S_FETCH: begin
        IRload     = 1'b1;
        PCload     = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        unique case (IR7_5)
          3'b000:  state_next = S_INPUT;
          3'b001:  state_next = S_OUTPUT;
          3'b010:  state_next = S_DEC;
          3'b011:  state_next = S_JNZ;
          default: state_next = S_HALT;
        endcase
      end
      S_INPUT: begin
        INmux = 1'b1;
        Aload = enter_edge;
        if (enter_edge) state_next = S_FETCH;
      end
      S_OUTPUT: begin
        OutE       = 1'b1;
        state_next = S_FETCH;
      end
      S_DEC: begin
        Aload      = 1'b1;
        state_next = S_FETCH;
      end
      S_JNZ: begin
        // Zero accumulator leaves the already-incremented PC in place.
        JNZmux     = 1'b1;
        PCload     = ~A;
        state_next = S_FETCH;
      end
      S_HALT: begin
        Halt = 1'b1;
        OutE = 1'b1;
      end
      default: state_next = S_START;
    endcase
  end

  assign state = state_reg;

endmodule

// File: tb/tb_ec1_controller.sv
// Directed-vector bench for ec1_controller; each check compares {state, strobes}.
module tb_ec1_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Enter = 1'b0;
  logic [2:0] IR7_5 = 3'b000;
  logic       A = 1'b0;
  logic       IRload, PCload, JNZmux, INmux, Aload, OutE, Halt;
  logic [2:0] state;

  int vec_count = 0;
  int err_count = 0;

  ec1_controller dut (
    .clk    (clk),
    .reset  (reset),
    .Enter  (Enter),
    .IR7_5  (IR7_5),
    .A      (A),
    .IRload (IRload),
    .PCload (PCload),
    .JNZmux (JNZmux),
    .INmux  (INmux),
    .Aload  (Aload),
    .OutE   (OutE),
    .Halt   (Halt),
    .state  (state)
  );

  always #5 clk = ~clk;

  // Strobe vector order: IRload PCload JNZmux INmux Aload OutE Halt
  localparam logic [6:0] NONE  = 7'b000_0000;
  localparam logic [6:0] FET   = 7'b110_0000;
  localparam logic [6:0] INP   = 7'b000_1000;
  localparam logic [6:0] INLD  = 7'b000_1100;
  localparam logic [6:0] OUTS  = 7'b000_0010;
  localparam logic [6:0] DECS  = 7'b000_0100;
  localparam logic [6:0] JNZL  = 7'b011_0000;
  localparam logic [6:0] JNZN  = 7'b001_0000;
  localparam logic [6:0] HLT   = 7'b000_0011;

  // Advance one clock, then drive inputs for the new cycle.
  task automatic step(input logic r, input logic [2:0] ir, input logic en, input logic a);
    @(posedge clk);
    #1;
    reset = r;
    IR7_5 = ir;
    Enter = en;
    A     = a;
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] st, input logic [6:0] strobes);
    logic [9:0] obs;
    logic [9:0] exp;
    obs = {state, IRload, PCload, JNZmux, INmux, Aload, OutE, Halt};
    exp = {st, strobes};
    vec_count++;
    assert (obs === exp) else begin
      err_count++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    // Power-on reset, released after two cycles
    step(1, 3'b000, 0, 0);
    step(1, 3'b000, 0, 0);
    chk("por_start", 3'b000, NONE);
    step(0, 3'b000, 0, 0);
    chk("por_start_last", 3'b000, NONE);
    step(0, 3'b000, 0, 0);
    chk("por_fetch", 3'b001, FET);

    // DEC / JNZ loop
    step(0, 3'b010, 0, 0); chk("decode1", 3'b010, NONE);
    step(0, 3'b010, 0, 0); chk("dec1", 3'b101, DECS);
    step(0, 3'b010, 0, 0); chk("fetch2", 3'b001, FET);
    step(0, 3'b011, 0, 0); chk("decode2", 3'b010, NONE);
    step(0, 3'b011, 0, 0); chk("jnz_a0", 3'b110, JNZL);
    step(0, 3'b010, 0, 0); chk("fetch3", 3'b001, FET);
    step(0, 3'b010, 0, 0); chk("decode3", 3'b010, NONE);
    step(0, 3'b010, 0, 0); chk("dec2", 3'b101, DECS);
    step(0, 3'b011, 0, 1); chk("fetch4", 3'b001, FET);
    step(0, 3'b011, 0, 1); chk("decode4", 3'b010, NONE);
    step(0, 3'b011, 0, 1); chk("jnz_a1", 3'b110, JNZN);

    // Mid-run reset held across two edges
    step(1, 3'b000, 0, 0); chk("pre_reset_fetch", 3'b001, FET);
    step(1, 3'b000, 0, 0); chk("midrst_start", 3'b000, NONE);
    step(0, 3'b000, 0, 0); chk("midrst_start2", 3'b000, NONE);
    step(0, 3'b000, 0, 0); chk("midrst_fetch", 3'b001, FET);
    step(0, 3'b000, 0, 0); chk("midrst_decode", 3'b010, NONE);

    // IN handshake: five idle cycles then a press
    for (int i = 0; i < 5; i++) begin
      step(0, 3'b000, 0, 0); chk("in_wait", 3'b011, INP);
    end
    step(0, 3'b000, 1, 0); chk("in_load", 3'b011, INLD);
    step(0, 3'b000, 1, 0); chk("in_fetch", 3'b001, FET);
    step(0, 3'b000, 1, 0); chk("in_decode", 3'b010, NONE);

    // Stale key: held through entry into INPUT
    step(0, 3'b000, 1, 0); chk("stale_noload", 3'b011, INP);
    step(0, 3'b000, 0, 0); chk("stale_release", 3'b011, INP);
    step(0, 3'b000, 1, 0); chk("stale_repress", 3'b011, INLD);
    step(0, 3'b000, 1, 0); chk("stale_fetch", 3'b001, FET);

    // OUT then HALT
    step(0, 3'b001, 0, 0); chk("out_decode", 3'b010, NONE);
    step(0, 3'b001, 0, 0); chk("out_exec", 3'b100, OUTS);
    step(0, 3'b100, 0, 0); chk("out_fetch", 3'b001, FET);
    step(0, 3'b100, 0, 0); chk("halt_decode", 3'b010, NONE);
    step(0, 3'b100, 0, 0); chk("halt_enter", 3'b111, HLT);
    for (int i = 0; i < 20; i++) begin
      step(0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("halt_hold", 3'b111, HLT);
    end

    // Reset out of HALT, then opcode 110 halts too
    step(1, 3'b110, 0, 0); chk("halt_pre_rst", 3'b111, HLT);
    step(0, 3'b110, 0, 0); chk("halt_rst_start", 3'b000, NONE);
    step(0, 3'b110, 0, 0); chk("op110_fetch", 3'b001, FET);
    step(0, 3'b110, 0, 0); chk("op110_decode", 3'b010, NONE);
    step(0, 3'b110, 0, 0); chk("op110_halt", 3'b111, HLT);

    // Reset during INPUT; a held key must not load afterwards
    step(1, 3'b000, 1, 0); chk("halt_pre_rst2", 3'b111, HLT);
    step(0, 3'b000, 1, 0); chk("rst2_start", 3'b000, NONE);
    step(0, 3'b000, 1, 0); chk("rst2_fetch", 3'b001, FET);
    step(0, 3'b000, 1, 0); chk("rst2_decode", 3'b010, NONE);
    step(1, 3'b000, 0, 0); chk("in_pre_rst", 3'b011, INP);
    step(0, 3'b000, 1, 0); chk("in_rst_start", 3'b000, NONE);
    step(0, 3'b000, 1, 0); chk("in_rst_fetch", 3'b001, FET);
    step(0, 3'b000, 1, 0); chk("in_rst_decode", 3'b010, NONE);
    step(0, 3'b000, 1, 0); chk("in_rst_stale", 3'b011, INP);
    step(0, 3'b000, 0, 0); chk("in_rst_release", 3'b011, INP);
    step(0, 3'b000, 1, 0); chk("in_rst_press", 3'b011, INLD);
    step(0, 3'b000, 0, 0); chk("in_rst_fetch2", 3'b001, FET);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/ec1_controller.md
# ec1_controller

Control unit for the EC-1 accumulator datapath. A Moore-style fetch/decode/execute FSM reads the 3-bit opcode and the accumulator-zero flag from the datapath, and drives its six load/select/enable strobes. It also synchronises the operator Enter key for the IN instruction and reports halt status. It sits beside the datapath in the EC-1 top level and is the only source of that datapath's control inputs.

## Interface
Parameters: none.

- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk
- Enter  in  1  debounced operator key, level, synchronous to clk
- IR7_5  in  3  opcode field from the instruction register
- A  in  1  accumulator-zero flag (1 = accumulator is 0)
- IRload  out  1  load IR from ROM
- PCload  out  1  load PC
- JNZmux  out  1  PC source select (0 = PC+1, 1 = IR[3:0] target)
- INmux  out  1  A source select (0 = A-1, 1 = Input)
- Aload  out  1  load accumulator
- OutE  out  1  output enable
- Halt  out  1  processor halted
- state  out  3  current state code, for debug/LEDs

## Operation
- State codes: START=000, FETCH=001, DECODE=010, INPUT=011, OUTPUT=100, DEC=101, JNZ=110, HALT=111.
- Outputs are decoded from the state register. PCload in JNZ additionally depends on A.
- Any strobe not listed for a state is 0.
- START: no strobes; next state FETCH.
- FETCH: IRload=1, PCload=1, JNZmux=0; next state DECODE.
- DECODE: no strobes. Next state by IR7_5:
  - 000 → INPUT
  - 001 → OUTPUT
  - 010 → DEC
  - 011 → JNZ
  - 100–111 → HALT (unused codes halt)
- INPUT: INmux=1. Aload = enter_edge. Stays in INPUT until enter_edge=1, then goes to FETCH on that same edge.
- OUTPUT: OutE=1; next state FETCH.
- DEC: INmux=0, Aload=1; next state FETCH. Decrement wraps 00→FF in the datapath; the controller does not care.
- JNZ: JNZmux=1, PCload=~A; next state FETCH.
  - A=1 (accumulator zero): no load; PC stays at the already-incremented value.
  - A=0: PC is loaded with the target.
- HALT: Halt=1, OutE=1 (final A stays visible). Absorbing state; only reset leaves it.
- Enter edge detection:
  - enter_q is a register updated every cycle.
  - enter_edge = Enter & ~enter_q.
  - enter_edge is used only in INPUT. An edge that occurs in any other state is discarded.
  - A key already held when INPUT is entered must be released and pressed again.
- reset has priority over all transitions: state←START and enter_q←0 on the next edge, from any state, including mid-INPUT and HALT.

## Timing
- Reset values (cycle after reset sampled high): state=000, Halt=0, and IRload, PCload, JNZmux, INmux, Aload, OutE all 0.
- First FETCH occurs 1 cycle after reset deasserts (START lasts exactly one cycle).
- Instruction lengths in cycles, counting FETCH, DECODE and execute:
  - OUT: 3
  - DEC: 3
  - JNZ: 3
  - HALT: 2 to reach HALT
  - IN: 3 + wait. Minimum 3 if the Enter edge is present on the first INPUT cycle.
- Datapath registers capture on the clock edge that ends the asserting state. IR and the opcode are therefore valid throughout DECODE.
- No combinational path from Enter to any output other than Aload in INPUT.

## Test plan
- Reset: hold reset 2 cycles in mid-run. Required: state=000 and all strobes 0 the cycle after. Then the sequence 001, 010 with IRload=PCload=1 in 001.
- DEC/JNZ loop: drive IR7_5 = 010, 011, 010, 011 … with A=0 then A=1 on the final JNZ. Required:
  - Aload=1, INmux=0 in each DEC.
  - JNZmux=1 and PCload=1 in JNZ when A=0.
  - PCload=0 in JNZ when A=1.
  - 3 cycles per instruction.
- IN handshake: IR7_5=000, Enter low for 5 cycles, then high for 3. Required: state=011 for 5 cycles with Aload=0. Aload=1 and INmux=1 for exactly 1 cycle on the first high cycle, then state=001.
- Stale key: Enter held high from FETCH through entry to INPUT. Required: no Aload. Enter low then high gives a single Aload pulse.
- OUT then HALT: IR7_5=001 then 100. Required: OutE=1 for one cycle in state 100. Then state 111 with Halt=1 and OutE=1 held for 20 cycles regardless of IR7_5/Enter. Opcode 110 also reaches HALT.
- Reset during INPUT and HALT: assert reset in each. Required: state=000, Halt=0 on the next edge. A following IN requires a fresh Enter edge.
